// File: rtl/chain_mixer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | chain_mixer_pkg : shared types and helpers for the chain mixer       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package chain_mixer_pkg;

  localparam int DEFAULT_TW = 16;
  localparam int MAX_STAGES = 256;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MIX   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  // Callers narrow the result to their own stage count with a size cast.
  function automatic logic [MAX_STAGES-1:0] onehot(input logic [7:0] idx);
    logic [MAX_STAGES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/chain_mixer_sequencer_phase_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | phase_timer : loadable down counter that expires when it hits zero   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module phase_timer
  import chain_mixer_pkg::*;
#(
  parameter int TW = DEFAULT_TW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic [TW-1:0] value,
  output logic          expired
);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value   = cnt_q;
  assign expired = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/chain_mixer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | chain_mixer_sequencer : steps one run through a chain of mixers      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module chain_mixer_sequencer
  import chain_mixer_pkg::*;
#(
  parameter int N_STAGES = 64,
  parameter int TW       = DEFAULT_TW,
  parameter int SW       = $clog2(N_STAGES + 1),
  parameter int IW       = $clog2(N_STAGES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [SW-1:0]       cfg_stages,
  input  logic [TW-1:0]       cfg_load,
  input  logic [TW-1:0]       cfg_mix,
  input  logic [TW-1:0]       cfg_flush,
  output logic                inlet_vlv,
  output logic [N_STAGES-1:0] reagent_vlv,
  output logic [N_STAGES-1:0] mix_en,
  output logic                outlet_vlv,
  output logic [IW-1:0]       stage_idx,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic                err
);

  function automatic logic [TW-1:0] phase_len(input logic [TW-1:0] cfg);
    return (cfg == '0) ? '0 : cfg - TW'(1);
  endfunction

  state_t               state_q, state_d;
  logic [IW-1:0]        stage_q, stage_d;
  logic                 abort_q, abort_d;
  logic [SW-1:0]        stages_q, stages_d;
  logic [TW-1:0]        load_q, load_d, mix_q, mix_d, flush_q, flush_d;

  logic                 inlet_q, inlet_d, outlet_q, outlet_d;
  logic [N_STAGES-1:0]  reagent_q, reagent_d, mixen_q, mixen_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 aborted_q, aborted_d, err_q, err_d;

  logic                 timer_load;
  logic [TW-1:0]        timer_load_val;
  logic [TW-1:0]        timer_value_unused;
  logic                 timer_expired;

  phase_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_load_val),
    .value    (timer_value_unused),
    .expired  (timer_expired)
  );

  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    abort_d  = abort_q;
    stages_d = stages_q;
    load_d   = load_q;
    mix_d    = mix_q;
    flush_d  = flush_q;
    err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A simultaneous abort suppresses the start entirely, including err.
        if (start && !abort) begin
          if (cfg_stages != '0 && cfg_stages <= SW'(N_STAGES)) begin
            state_d  = ST_LOAD;
            stage_d  = '0;
            abort_d  = 1'b0;
            stages_d = cfg_stages;
            load_d   = cfg_load;
            mix_d    = cfg_mix;
            flush_d  = cfg_flush;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_FLUSH;
          abort_d = 1'b1;
        end else if (timer_expired) begin
          state_d = ST_MIX;
        end
      end
      ST_MIX: begin
        if (abort) begin
          state_d = ST_FLUSH;
          abort_d = 1'b1;
        end else if (timer_expired) begin
          if (SW'(stage_q) == stages_q - SW'(1)) begin
            state_d = ST_FLUSH;
          end else begin
            stage_d = stage_q + IW'(1);
            state_d = ST_LOAD;
          end
        end
      end
      ST_FLUSH: begin
        if (abort) begin
          abort_d = 1'b1;
        end
        if (timer_expired) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Every change of state into a timed phase is a phase entry.
  always_comb begin
    timer_load     = (state_d != state_q);
    timer_load_val = '0;
    case (state_d)
      ST_LOAD:  timer_load_val = phase_len(load_d);
      ST_MIX:   timer_load_val = phase_len(mix_d);
      ST_FLUSH: timer_load_val = phase_len(flush_d);
      default:  timer_load = 1'b0;
    endcase
  end

  always_comb begin
    busy_d    = (state_d == ST_LOAD) || (state_d == ST_MIX) || (state_d == ST_FLUSH);
    inlet_d   = (state_d == ST_LOAD) && (stage_d == '0);
    outlet_d  = (state_d == ST_FLUSH);
    reagent_d = (state_d == ST_LOAD) ? N_STAGES'(onehot(8'(stage_d))) : '0;
    mixen_d   = (state_d == ST_MIX)  ? N_STAGES'(onehot(8'(stage_d))) : '0;
    done_d    = (state_d == ST_FIN) && !abort_d;
    aborted_d = (state_d == ST_FIN) && abort_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      stage_q   <= '0;
      abort_q   <= 1'b0;
      stages_q  <= '0;
      load_q    <= '0;
      mix_q     <= '0;
      flush_q   <= '0;
      inlet_q   <= 1'b0;
      outlet_q  <= 1'b0;
      reagent_q <= '0;
      mixen_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      abort_q   <= abort_d;
      stages_q  <= stages_d;
      load_q    <= load_d;
      mix_q     <= mix_d;
      flush_q   <= flush_d;
      inlet_q   <= inlet_d;
      outlet_q  <= outlet_d;
      reagent_q <= reagent_d;
      mixen_q   <= mixen_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      err_q     <= err_d;
    end
  end

  assign inlet_vlv   = inlet_q;
  assign outlet_vlv  = outlet_q;
  assign reagent_vlv = reagent_q;
  assign mix_en      = mixen_q;
  assign stage_idx   = stage_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_chain_mixer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_chain_mixer_sequencer : directed self-checking bench              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_chain_mixer_sequencer;

  localparam int N  = 64;
  localparam int TW = 16;
  localparam int SW = 7;
  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [SW-1:0] cfg_stages = '0;
  logic [TW-1:0] cfg_load = '0, cfg_mix = '0, cfg_flush = '0;
  logic          inlet_vlv, outlet_vlv, busy, done, aborted, err;
  logic [N-1:0]  reagent_vlv, mix_en;
  logic [IW-1:0] stage_idx;

  int errors = 0;
  int checks = 0;

  chain_mixer_sequencer #(.N_STAGES(N), .TW(TW), .SW(SW), .IW(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_stages(cfg_stages), .cfg_load(cfg_load), .cfg_mix(cfg_mix), .cfg_flush(cfg_flush),
    .inlet_vlv(inlet_vlv), .reagent_vlv(reagent_vlv), .mix_en(mix_en), .outlet_vlv(outlet_vlv),
    .stage_idx(stage_idx), .busy(busy), .done(done), .aborted(aborted), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ($countones(reagent_vlv | mix_en) > 1 || (|reagent_vlv && |mix_en)) begin
        errors++;
        $display("FAIL onehot_invariant got reagent=%h mix=%h required at most one bit", reagent_vlv, mix_en);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({inlet_vlv, outlet_vlv, busy, done, aborted, err, stage_idx} !== '0 ||
        reagent_vlv !== '0 || mix_en !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b stage=%0d reagent=%h mix=%h required all 0",
               busy, stage_idx, reagent_vlv, mix_en);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [4:0]    exp_st;
    logic [N-1:0]  exp_r, exp_m;
    logic [IW-1:0] exp_stg;
    cfg_stages = 7'd2; cfg_load = 16'd3; cfg_mix = 16'd4; cfg_flush = 16'd2;
    start = 1'b1;
    for (int c = 0; c <= 17; c++) begin
      @(negedge clk);
      if (c == 0) begin
        start = 1'b0;
        cfg_stages = 7'd5; cfg_load = 16'd9;
      end
      exp_r = '0; exp_m = '0; exp_stg = '0;
      if (c < 3)       begin exp_st = 5'b11000; exp_r[0] = 1'b1; end
      else if (c < 7)  begin exp_st = 5'b10000; exp_m[0] = 1'b1; end
      else if (c < 10) begin exp_st = 5'b10000; exp_r[1] = 1'b1; exp_stg = 6'd1; end
      else if (c < 14) begin exp_st = 5'b10000; exp_m[1] = 1'b1; exp_stg = 6'd1; end
      else if (c < 16) begin exp_st = 5'b10100; exp_stg = 6'd1; end
      else if (c == 16) exp_st = 5'b00010;
      else              exp_st = 5'b00000;
      checks++;
      if ({busy, inlet_vlv, outlet_vlv, done, aborted} !== exp_st) begin
        errors++;
        $display("FAIL basic_status c=%0d got %b required %b", c, {busy, inlet_vlv, outlet_vlv, done, aborted}, exp_st);
      end
      checks++;
      if (reagent_vlv !== exp_r || mix_en !== exp_m) begin
        errors++;
        $display("FAIL basic_valves c=%0d got r=%h m=%h required r=%h m=%h", c, reagent_vlv, mix_en, exp_r, exp_m);
      end
      if (c < 16) begin
        checks++;
        if (stage_idx !== exp_stg) begin
          errors++;
          $display("FAIL basic_stage c=%0d got %0d required %0d", c, stage_idx, exp_stg);
        end
      end
    end
  endtask

  task automatic test_bad_cfg();
    logic [SW-1:0] bad [2];
    bad[0] = 7'd0; bad[1] = 7'd65;
    for (int i = 0; i < 2; i++) begin
      cfg_stages = bad[i]; cfg_load = 16'd1; cfg_mix = 16'd1; cfg_flush = 16'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({err, busy, inlet_vlv, outlet_vlv} !== 4'b1000 || reagent_vlv !== '0 || mix_en !== '0) begin
        errors++;
        $display("FAIL bad_cfg stages=%0d got err=%b busy=%b required err=1 busy=0", bad[i], err, busy);
      end
      @(negedge clk);
      checks++;
      if ({err, busy} !== 2'b00) begin
        errors++;
        $display("FAIL bad_cfg_pulse stages=%0d got err=%b busy=%b required 0 0", bad[i], err, busy);
      end
    end
  endtask

  task automatic test_full_chain();
    int busy_cnt = 0;
    int max_stg = 0;
    logic done_seen = 1'b0;
    logic [N-1:0] exp_r, exp_m;
    cfg_stages = 7'd64; cfg_load = '0; cfg_mix = '0; cfg_flush = '0;
    start = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (!busy) begin
        done_seen = done;
        break;
      end
      exp_r = '0; exp_m = '0;
      if (c < 128 && c % 2 == 0) exp_r[c/2] = 1'b1;
      if (c < 128 && c % 2 == 1) exp_m[c/2] = 1'b1;
      checks++;
      if (reagent_vlv !== exp_r || mix_en !== exp_m) begin
        errors++;
        $display("FAIL full_valves c=%0d got r=%h m=%h required r=%h m=%h", c, reagent_vlv, mix_en, exp_r, exp_m);
      end
      busy_cnt++;
      if (int'(stage_idx) > max_stg) max_stg = int'(stage_idx);
    end
    checks++;
    if (busy_cnt != 129) begin
      errors++;
      $display("FAIL full_busy_len got %0d required 129", busy_cnt);
    end
    checks++;
    if (max_stg != 63) begin
      errors++;
      $display("FAIL full_max_stage got %0d required 63", max_stg);
    end
    checks++;
    if (done_seen !== 1'b1) begin
      errors++;
      $display("FAIL full_done got %b required 1", done_seen);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    cfg_stages = 7'd3; cfg_load = 16'd2; cfg_mix = 16'd5; cfg_flush = 16'd3;
    start = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      if (c == 11) begin
        checks++;
        if (mix_en[1] !== 1'b1 || stage_idx !== 6'd1) begin
          errors++;
          $display("FAIL abort_pre got mix=%h stage=%0d required mix bit1 stage 1", mix_en, stage_idx);
        end
        abort = 1'b1;
      end
      if (c >= 12 && c <= 14) begin
        checks++;
        if ({busy, outlet_vlv, done, aborted} !== 4'b1100 || mix_en !== '0 ||
            reagent_vlv !== '0 || stage_idx !== 6'd1) begin
          errors++;
          $display("FAIL abort_flush c=%0d got busy=%b out=%b mix=%h stage=%0d required flush stage 1",
                   c, busy, outlet_vlv, mix_en, stage_idx);
        end
      end
      if (c == 15 || c == 16) begin
        checks++;
        if ({busy, outlet_vlv, done, aborted} !== ((c == 15) ? 4'b0001 : 4'b0000)) begin
          errors++;
          $display("FAIL abort_end c=%0d got busy=%b out=%b done=%b aborted=%b", c, busy, outlet_vlv, done, aborted);
        end
      end
    end
  endtask

  task automatic test_start_ignore();
    cfg_stages = 7'd1; cfg_load = 16'd1; cfg_mix = 16'd1; cfg_flush = 16'd1;
    start = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      if (c == 3) start = 1'b0;
      checks++;
      if ({busy, done, err} !== ((c < 3) ? 3'b100 : (c == 3) ? 3'b010 : 3'b000)) begin
        errors++;
        $display("FAIL start_held c=%0d got busy=%b done=%b err=%b", c, busy, done, err);
      end
    end
    cfg_stages = 7'd0;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checks++;
    if ({busy, err} !== 2'b00) begin
      errors++;
      $display("FAIL start_abort_bad got busy=%b err=%b required 0 0", busy, err);
    end
    cfg_stages = 7'd2;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, err, inlet_vlv} !== 3'b000 || reagent_vlv !== '0) begin
      errors++;
      $display("FAIL start_abort_good got busy=%b err=%b inlet=%b required 0", busy, err, inlet_vlv);
    end
  endtask

  task automatic test_async_reset();
    cfg_stages = 7'd2; cfg_load = 16'd5; cfg_mix = 16'd2; cfg_flush = 16'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, inlet_vlv} !== 2'b11 || reagent_vlv[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre got busy=%b inlet=%b required 1 1", busy, inlet_vlv);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({inlet_vlv, outlet_vlv, busy, done, aborted, err, stage_idx} !== '0 ||
        reagent_vlv !== '0 || mix_en !== '0) begin
      errors++;
      $display("FAIL rst_async got busy=%b inlet=%b reagent=%h required all 0", busy, inlet_vlv, reagent_vlv);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, aborted} !== 3'b000) begin
        errors++;
        $display("FAIL rst_after c=%0d got busy=%b done=%b aborted=%b required 0", c, busy, done, aborted);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_cfg();
    test_full_chain();
    test_abort();
    test_start_ignore();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
